// File: rtl/morse_rx.sv
// morse_rx: Morse key receiver. Synchronizes the player key, measures mark and
// space durations in prescaled ticks, and classifies each mark as a dot or a
// dash against a unit length U selected by the difficulty bus. A gap of 3*U
// closes the symbol, which is emitted as a one-cycle sym_valid pulse.
// Optional feature macro: MORSE_RX_ERR_EN. When it is defined, a sixth element
// discards the symbol and pulses err. When it is undefined, err is tied to 0
// and elements beyond the fifth are ignored.
module morse_rx #(
  parameter int TICK_DIV = 50000,
  parameter int UNIT0    = 400,
  parameter int UNIT1    = 300,
  parameter int UNIT2    = 200,
  parameter int UNIT3    = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] difficulty,
  input  logic       key,
  output logic [4:0] sym_code,
  output logic [2:0] sym_len,
  output logic       sym_valid,
  output logic       busy,
  output logic       err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MARK  = 2'd1;
  localparam logic [1:0] S_SPACE = 2'd2;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;
  logic          key_s1_q, key_s1_d;
  logic          key_s2_q, key_s2_d;
  logic          key_dl_q, key_dl_d;
  logic          key_rise, key_fall;
  logic [1:0]    state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   cnt_inc;
  logic [15:0]   unit_q, unit_d;
  logic [15:0]   unit_sel;
  logic [15:0]   two_u, three_u;
  logic [4:0]    elems_q, elems_d;
  logic [2:0]    len_q, len_d;
  logic [4:0]    sym_code_q, sym_code_d;
  logic [2:0]    sym_len_q, sym_len_d;
  logic          sym_valid_q, sym_valid_d;
  logic          dash;
`ifdef MORSE_RX_ERR_EN
  logic          err_q, err_d;
`endif

  // Free-running prescaler: one tick every TICK_DIV clocks.
  always_comb begin
    tick  = (pre_q == PRE_MAX);
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  // Two-flop synchronizer plus one delay stage for edge detection.
  always_comb begin
    key_s1_d = key;
    key_s2_d = key_s1_q;
    key_dl_d = key_s2_q;
    key_rise = key_s2_q & ~key_dl_q;
    key_fall = ~key_s2_q & key_dl_q;
  end

  // Unit length lookup and the 2U / 3U thresholds of the latched unit.
  always_comb begin
    unique case (difficulty)
      2'b00:   unit_sel = 16'(UNIT0);
      2'b01:   unit_sel = 16'(UNIT1);
      2'b10:   unit_sel = 16'(UNIT2);
      default: unit_sel = 16'(UNIT3);
    endcase
    two_u   = {unit_q[14:0], 1'b0};
    three_u = two_u + unit_q;
  end

  // Decoder FSM. Thresholds compare the counter value including this cycle's
  // tick, so a window of N*TICK_DIV clocks always measures exactly N ticks.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    unit_d      = unit_q;
    elems_d     = elems_q;
    len_d       = len_q;
    sym_code_d  = sym_code_q;
    sym_len_d   = sym_len_q;
    sym_valid_d = 1'b0;
`ifdef MORSE_RX_ERR_EN
    err_d       = 1'b0;
`endif
    cnt_inc = (tick && (cnt_q != '1)) ? cnt_q + 16'd1 : cnt_q;
    dash    = (cnt_inc >= two_u);

    unique case (state_q)
      S_IDLE: begin
        if (key_rise) begin
          state_d = S_MARK;
          cnt_d   = '0;
          unit_d  = unit_sel;
          elems_d = '0;
          len_d   = '0;
        end
      end

      S_MARK: begin
        cnt_d = cnt_inc;
        if (key_fall) begin
          cnt_d = '0;
          if (len_q == 3'd5) begin
`ifdef MORSE_RX_ERR_EN
            state_d = S_IDLE;
            err_d   = 1'b1;
`else
            state_d = S_SPACE;
`endif
          end else begin
            elems_d = elems_q | ({4'b0, dash} << len_q);
            len_d   = len_q + 3'd1;
            state_d = S_SPACE;
          end
        end
      end

      S_SPACE: begin
        cnt_d = cnt_inc;
        if (cnt_inc >= three_u) begin
          sym_valid_d = 1'b1;
          sym_code_d  = elems_q;
          sym_len_d   = len_q;
          // A rise on the closing edge starts the next symbol directly.
          if (key_rise) begin
            state_d = S_MARK;
            cnt_d   = '0;
            unit_d  = unit_sel;
            elems_d = '0;
            len_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (key_rise) begin
          state_d = S_MARK;
          cnt_d   = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q       <= '0;
      key_s1_q    <= 1'b0;
      key_s2_q    <= 1'b0;
      key_dl_q    <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      unit_q      <= '0;
      elems_q     <= '0;
      len_q       <= '0;
      sym_code_q  <= '0;
      sym_len_q   <= '0;
      sym_valid_q <= 1'b0;
`ifdef MORSE_RX_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
      pre_q       <= pre_d;
      key_s1_q    <= key_s1_d;
      key_s2_q    <= key_s2_d;
      key_dl_q    <= key_dl_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      unit_q      <= unit_d;
      elems_q     <= elems_d;
      len_q       <= len_d;
      sym_code_q  <= sym_code_d;
      sym_len_q   <= sym_len_d;
      sym_valid_q <= sym_valid_d;
`ifdef MORSE_RX_ERR_EN
      err_q       <= err_d;
`endif
    end
  end

  assign sym_code  = sym_code_q;
  assign sym_len   = sym_len_q;
  assign sym_valid = sym_valid_q;
  assign busy      = (state_q != S_IDLE);
`ifdef MORSE_RX_ERR_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: doc/morse_rx.md
MORSE_RX -- requirements
Module: morse_rx

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000, meaning clocks per timing tick (1 ms at 50 MHz).
REQ-002 The block SHALL have parameter UNIT0, default 400, meaning unit length in ticks for difficulty 2'b00.
REQ-003 The block SHALL have parameter UNIT1, default 300, meaning unit length in ticks for difficulty 2'b01.
REQ-004 The block SHALL have parameter UNIT2, default 200, meaning unit length in ticks for difficulty 2'b10.
REQ-005 The block SHALL have parameter UNIT3, default 100, meaning unit length in ticks for difficulty 2'b11.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all flops on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port difficulty, input, 2 bits: unit-length select, same encoding as the game's difficulty bus.
REQ-009 The block SHALL have port key, input, 1 bit: player key, debounced but asynchronous; 1 = pressed.
REQ-010 The block SHALL have port sym_code, output, 5 bits: decoded elements; bit i = element i, first element in bit 0; 1 = dash, 0 = dot.
REQ-011 The block SHALL have port sym_len, output, 3 bits: element count 1..5 of sym_code.
REQ-012 The block SHALL have port sym_valid, output, 1 bit: one-cycle pulse qualifying sym_code/sym_len.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-014 The block SHALL have port err, output, 1 bit: overflow pulse (see Configuration).

Function
REQ-015 key SHALL pass a 2-flop synchronizer; all decoding uses the synchronized key (2-cycle input latency).
REQ-016 A prescaler SHALL assert an internal tick for one clock every TICK_DIV clocks, free-running from reset.
REQ-017 Unit length U SHALL be latched from difficulty on each IDLE->MARK transition; difficulty changes mid-symbol SHALL have no effect until the next symbol.
REQ-018 The state machine SHALL have states IDLE, MARK and SPACE.
REQ-019 IDLE->MARK on synchronized key rising; element count and sym_code shift register clear, tick counter clears.
REQ-020 In MARK and SPACE, a 16-bit tick counter SHALL increment on each tick and saturate at 16'hFFFF.
REQ-021 MARK->SPACE on key falling: element stored as dot if count < 2*U, else dash; element count increments; counter clears.
REQ-022 SPACE->MARK on key rising before the counter reaches 3*U; counter clears; element continues the same symbol.
REQ-023 SPACE->IDLE on the edge where the counter reaches 3*U; on that edge sym_valid SHALL register 1 for exactly one cycle with sym_code/sym_len.
REQ-024 sym_code/sym_len SHALL hold their last emitted values until the next emission; unused upper sym_code bits SHALL be 0.
REQ-025 A sixth element SHALL discard the symbol: state returns to IDLE at that key falling, no sym_valid, err pulses one cycle (macro on).
REQ-026 A key rising in the same cycle the gap reaches 3*U SHALL emit the pending symbol and begin a new symbol in MARK (IDLE not visited for a cycle).
REQ-027 Arithmetic SHALL use 16 bits; 2*U and 3*U computed without truncation for U <= 21845.

Reset
REQ-028 reset SHALL force state IDLE, counters 0, synchronizer flops 0, sym_code 0, sym_len 0, sym_valid 0, busy 0, err 0 on the next clk edge.
REQ-029 reset asserted mid-symbol SHALL discard the symbol with no sym_valid or err pulse, and takes priority over every other event.

Configuration
REQ-030 With MORSE_RX_ERR_EN defined, overflow detection of REQ-025 SHALL drive err.
REQ-031 Without MORSE_RX_ERR_EN, err SHALL be constant 0, and a sixth element SHALL be ignored (symbol keeps first five elements and is emitted normally).

Verification (bench: TICK_DIV=4, UNIT1=10, difficulty=2'b01)
REQ-032 Press 5 ticks, release 35 ticks -> one sym_valid, sym_code=5'b00000, sym_len=1 ("E").
REQ-033 Dash 30 ticks, gap 10, dot 5, gap 10, dash 30, gap 35 -> sym_code=5'b00101, sym_len=3 ("K").
REQ-034 Press exactly 20 ticks -> dash; 19 ticks -> dot (2*U boundary).
REQ-035 Six dots with 10-tick gaps -> macro on: err pulse, no sym_valid; macro off: sym_valid, sym_len=5, sym_code=0.
REQ-036 Change difficulty to 2'b11 during first element of "A" -> decoded with U=10: sym_code=5'b00010, sym_len=2.
REQ-037 reset asserted during second element of a symbol -> all outputs 0, busy 0, no sym_valid afterwards until a new symbol completes.
